// File: rtl/dffmem_host.sv
// dffmem_host: byte-serial command front-end for the 8x16 DFF memory.
// Turns write/read commands into write strobes and two-byte responses.
module dffmem_host #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WLO,
    WHI,
    WSTB,
    RADR,
    RCAP,
    RLO,
    RHI
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] adr_d;
  logic              we_d;
  logic [DATA_W-1:0] din_d;
  logic              rv_d;
  logic [7:0]        rd_d;
  logic [7:0]        rbuf_q;
  logic [7:0]        rbuf_d;
  logic [7:0]        err_d;

  logic cmd_fire;
  logic rsp_fire;
  logic cmd_bad;
  logic cmd_wr;
  logic cmd_rd;

  assign cmd_ready = rst_n & ((state_q == IDLE) |
                              (state_q == WLO)  |
                              (state_q == WHI));
  assign busy      = (state_q != IDLE);

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;

  // exactly one of bad/wr/rd is set for any byte
  assign cmd_bad   = |cmd_data[6:3];
  assign cmd_wr    = ~cmd_bad & cmd_data[7];
  assign cmd_rd    = ~cmd_bad & ~cmd_data[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_adr   <= '0;
      mem_we    <= 1'b0;
      mem_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rbuf_q    <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      state_q   <= state_d;
      mem_adr   <= adr_d;
      mem_we    <= we_d;
      mem_din   <= din_d;
      rsp_valid <= rv_d;
      rsp_data  <= rd_d;
      rbuf_q    <= rbuf_d;
      err_cnt   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = mem_adr;
    we_d    = 1'b0;
    din_d   = mem_din;
    rv_d    = rsp_valid;
    rd_d    = rsp_data;
    rbuf_d  = rbuf_q;
    err_d   = err_cnt;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          unique case (1'b1)
            cmd_bad: begin
              if (err_cnt != 8'hFF) begin
                err_d = err_cnt + 8'd1;
              end
            end
            cmd_wr: begin
              adr_d   = cmd_data[ADDR_W-1:0];
              state_d = WLO;
            end
            cmd_rd: begin
              adr_d   = cmd_data[ADDR_W-1:0];
              state_d = RADR;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
      WLO: begin
        if (cmd_fire) begin
          din_d[7:0] = cmd_data;
          state_d    = WHI;
        end
      end
      WHI: begin
        if (cmd_fire) begin
          din_d[DATA_W-1:8] = cmd_data;
          we_d              = 1'b1;
          state_d           = WSTB;
        end
      end
      WSTB: begin
        state_d = IDLE;
      end
      RADR: begin
        state_d = RCAP;
      end
      // mem_dout now reflects the address presented in RADR
      RCAP: begin
        rbuf_d  = mem_dout[DATA_W-1:8];
        rv_d    = 1'b1;
        rd_d    = mem_dout[7:0];
        state_d = RLO;
      end
      RLO: begin
        if (rsp_fire) begin
          rd_d    = rbuf_q;
          state_d = RHI;
        end
      end
      RHI: begin
        if (rsp_fire) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
